// File: rtl/md_unit_e.sv
// md_unit_e -- execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
//
// Owns HI/LO and a multi-cycle busy counter. A mult/div issued while idle is
// evaluated at once into a pending result. That result is committed to HI/LO
// when the counter expires, so busy stays high for exactly MULT_CYCLES or
// DIV_CYCLES cycles after the start cycle.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset (aborts any in-flight op)
//   md_op     in   4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                     7 mfhi, 8 mflo, 9-15 none
//   rs_val    in  32  forwarded Rs operand
//   rt_val    in  32  forwarded Rt operand
//   busy      out  1  registered; mult/div in flight
//   start     out  1  md_op is 1-4 and unit idle
//   md_stall  out  1  busy | start, for D-stage hazard logic
//   md_rd     out 32  HI for mfhi, LO for mflo, else 0
//   hi_out    out 32  current HI
//   lo_out    out 32  current LO
module md_unit_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        start,
    output logic        md_stall,
    output logic [31:0] md_rd,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     pend_hi_q, pend_lo_q;
    logic            pend_wr_q;

    logic [31:0]     res_hi_d, res_lo_d;
    logic            res_wr_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_ovf;
    logic signed [31:0] dvs, q_s, r_s;
    logic [31:0]        dvu, q_u, r_u;

    // Both operands signed, so they are sign-extended to 64 bits before the multiply.
    assign prod_s = $signed(rs_val) * $signed(rt_val);
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Divisors are forced to 1 for divide-by-zero and for the single signed
    // overflow case; those results are discarded or overridden below, so the
    // dividers never see an undefined operation.
    assign div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign dvs     = (rt_val == 32'd0 || div_ovf) ? 32'sd1 : $signed(rt_val);
    assign dvu     = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign q_s     = $signed(rs_val) / dvs;
    assign r_s     = $signed(rs_val) % dvs;
    assign q_u     = rs_val / dvu;
    assign r_u     = rs_val % dvu;

    always_comb begin
        res_hi_d = '0;
        res_lo_d = '0;
        res_wr_d = 1'b0;
        case (md_op)
            4'd1: begin
                {res_hi_d, res_lo_d} = prod_s;
                res_wr_d = 1'b1;
            end
            4'd2: begin
                {res_hi_d, res_lo_d} = prod_u;
                res_wr_d = 1'b1;
            end
            4'd3: begin
                if (div_ovf) begin
                    res_hi_d = '0;
                    res_lo_d = 32'h8000_0000;
                end else begin
                    res_hi_d = r_s;
                    res_lo_d = q_s;
                end
                res_wr_d = (rt_val != 32'd0);
            end
            4'd4: begin
                res_hi_d = r_u;
                res_lo_d = q_u;
                res_wr_d = (rt_val != 32'd0);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign start    = !busy && (md_op >= 4'd1) && (md_op <= 4'd4);
    assign md_stall = busy | start;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

    always_comb begin
        md_rd = '0;
        if (md_op == 4'd7)
            md_rd = hi_q;
        else if (md_op == 4'd8)
            md_rd = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_hi_q <= res_hi_d;
                        pend_lo_q <= res_lo_d;
                        pend_wr_q <= res_wr_d;
                        cnt_q     <= (md_op <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state_q   <= S_RUN;
                    end else if (md_op == 4'd5) begin
                        hi_q <= rs_val;
                    end else if (md_op == 4'd6) begin
                        lo_q <= rs_val;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CW'(1)) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
